// File: rtl/lsu_ctrl.sv
// Load/store unit: turns core memory requests into a valid/ready bus access,
// stalls the core until completion and formats load data for write-back.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        fault,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    // Abort fires in the cycle the count of busy cycles reaches TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cap_q, cap_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;

    logic req, f3_ok, misalign, legal, xfer_done, abort;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin : decode
        req = MemRead | MemWrite;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~MemWrite;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        legal = f3_ok & ~misalign;
    end

    // A completing handshake wins over a timeout landing in the same cycle.
    always_comb begin : handshake
        unique case (state_q)
            REQ:     xfer_done = bus_ready & (we_q | bus_rvalid);
            WAIT:    xfer_done = bus_rvalid;
            default: xfer_done = 1'b0;
        endcase
        abort = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == CNT_LAST) && !xfer_done;
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        unique case (state_q)
            IDLE: begin
                if (req && legal) begin
                    state_d = REQ;
                    addr_d  = {addr[31:2], 2'b00};
                    we_d    = MemWrite;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    cnt_d   = 8'd0;
                    cap_d   = 32'd0;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'd0;
                    if (MemWrite) begin
                        case (funct3[1:0])
                            2'b00: begin
                                wstrb_d = 4'b0001 << addr[1:0];
                                wdata_d = {4{WriteData[7:0]}};
                            end
                            2'b01: begin
                                wstrb_d = 4'b0011 << {addr[1], 1'b0};
                                wdata_d = {2{WriteData[15:0]}};
                            end
                            default: begin
                                wstrb_d = 4'b1111;
                                wdata_d = WriteData;
                            end
                        endcase
                    end
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (xfer_done) begin
                    state_d = DONE;
                    if (!we_q) cap_d = fmt_load(f3_q, off_q, bus_rdata);
                end else if (abort) begin
                    state_d = DONE;
                    cap_d   = 32'd0;
                end else if (state_q == REQ && bus_ready) begin
                    state_d = WAIT;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : data_reg
        if (!reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            cnt_q   <= 8'd0;
            cap_q   <= 32'd0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // Outputs are forced low while reset is held, independent of core inputs.
    always_comb begin : outputs
        Stall     = 1'b0;
        fault     = 1'b0;
        bus_err   = abort;
        bus_valid = 1'b0;
        ReadData  = 32'd0;
        unique case (state_q)
            IDLE: begin
                Stall = req & legal;
                fault = req & ~legal;
            end
            REQ: begin
                Stall     = 1'b1;
                bus_valid = 1'b1;
            end
            WAIT: Stall = 1'b1;
            DONE: ReadData = cap_q;
        endcase
        if (!reset) begin
            Stall   = 1'b0;
            fault   = 1'b0;
            bus_err = 1'b0;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: per-operation expected timeline built from
// the access rules, compared every cycle, plus directed literal checks.
module tb_lsu_ctrl;
    localparam int TO   = 8;
    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Stall, fault, bus_err, bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .fault(fault), .bus_err(bus_err), .bus_valid(bus_valid),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle timeline of the current operation.
    logic        e_stall [MAXC];
    logic        e_valid [MAXC];
    logic        e_fault [MAXC];
    logic        e_err   [MAXC];
    logic        e_done  [MAXC];
    logic        s_ready [MAXC];
    logic        s_rvalid[MAXC];
    logic [31:0] e_rd, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_we, e_chkwd;
    int          cur = 0;
    bit          active = 1'b0;

    // Observations of the last operation, for literal checks.
    logic [31:0] o_rd, o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    int          o_stall_n, o_valid_n, o_err_n, o_fault_n;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned lane_b, lane_h;
        int v;
        lane_b = (w >> (8 * a[1:0])) & 32'hFF;
        lane_h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000: begin v = int'(lane_b); if (v >= 128) v -= 256; return 32'(v); end
            3'b100: return 32'(lane_b);
            3'b001: begin v = int'(lane_h); if (v >= 32768) v -= 65536; return 32'(v); end
            3'b101: return 32'(lane_h);
            default: return w;
        endcase
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (active) begin
                chk1("stall", Stall, e_stall[cur]);
                chk1("bus_valid", bus_valid, e_valid[cur]);
                chk1("fault", fault, e_fault[cur]);
                chk1("bus_err", bus_err, e_err[cur]);
                if (Stall) o_stall_n++;
                if (bus_valid) o_valid_n++;
                if (bus_err) o_err_n++;
                if (fault) o_fault_n++;
                if (bus_valid) begin
                    o_addr = bus_addr; o_wstrb = bus_wstrb; o_wdata = bus_wdata;
                end
                if (e_valid[cur]) begin
                    chk("bus_addr", bus_addr, e_addr);
                    chk1("bus_we", bus_we, e_we);
                    chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e_wstrb});
                    if (e_chkwd) chk("bus_wdata", bus_wdata, e_wdata);
                end
                if (e_done[cur]) begin
                    chk("readdata", ReadData, e_rd);
                    o_rd = ReadData;
                end
                if (e_fault[cur]) chk("readdata_fault", ReadData, 32'd0);
            end
        end
    end

    // One core request; rdly = REQ cycles before ready, rvdly = cycles from ready to rvalid.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int rdly, input int rvdly);
        bit st, ok;
        int nb, c, busy, ncyc;
        st = wr;
        for (int i = 0; i < MAXC; i++) begin
            e_stall[i] = 0; e_valid[i] = 0; e_fault[i] = 0; e_err[i] = 0;
            e_done[i] = 0; s_ready[i] = 0; s_rvalid[i] = 0;
        end
        o_stall_n = 0; o_valid_n = 0; o_err_n = 0; o_fault_n = 0;
        o_rd = 32'hX; o_addr = 32'hX; o_wstrb = 4'hX; o_wdata = 32'hX;
        nb = 1 << f3[1:0];
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (ok && (a % nb) != 0) ok = 0;
        e_addr  = a & ~32'h3;
        e_we    = st;
        e_chkwd = st;
        e_wstrb = 4'd0;
        e_wdata = 32'd0;
        e_rd    = 32'd0;
        if (st && ok) begin
            e_wstrb = 4'(((1 << nb) - 1) << a[1:0]);
            for (int k = 0; k < 4; k++) e_wdata[8*k +: 8] = wd[8*(k % nb) +: 8];
        end
        if (!ok) begin
            e_fault[0] = 1;
            ncyc = 2;
        end else begin
            e_stall[0] = 1;
            c = st ? rdly + 1 : rdly + 1 + rvdly;
            busy = (c > TO) ? TO : c;
            for (int k = 1; k <= busy; k++) begin
                e_stall[k] = 1;
                e_valid[k] = (k <= rdly + 1);
            end
            if (c > TO) e_err[busy] = 1;
            if (rdly + 1 < MAXC) s_ready[rdly + 1] = 1;
            if (!st && rdly + 1 + rvdly < MAXC) s_rvalid[rdly + 1 + rvdly] = 1;
            if (!st || c > TO) e_done[busy + 1] = 1;
            if (!st && c <= TO) e_rd = model_load(f3, a, rdata);
            ncyc = busy + 3;
        end
        for (int i = 0; i < ncyc; i++) begin
            if (i == 0) begin
                MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; WriteData = wd;
            end else begin
                MemRead   = (i == ncyc - 1) ? 1'b0 : 1'($urandom);
                MemWrite  = (i == ncyc - 1) ? 1'b0 : 1'($urandom);
                funct3    = 3'($urandom);
                addr      = $urandom;
                WriteData = $urandom;
            end
            bus_ready  = s_ready[i];
            bus_rvalid = s_rvalid[i];
            bus_rdata  = s_rvalid[i] ? rdata : $urandom;
            cur = i;
            active = 1'b1;
            @(posedge clk); #1;
        end
        active = 1'b0;
        MemRead = 0; MemWrite = 0; bus_ready = 0; bus_rvalid = 0;
    endtask

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int op, f3r, rdly, rvdly;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readdata", ReadData, 32'd0);
        chk1("rst_stall", Stall, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_bus_valid", bus_valid, 1'b0);
        chk1("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // SW 0x100
        run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0);
        chk("sw_addr", o_addr, 32'h100);
        chk("sw_wstrb", {28'd0, o_wstrb}, 32'hF);
        chk("sw_wdata", o_wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", 32'(o_stall_n), 32'd2);
        // SB 0x103
        run_op(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 0, 0);
        chk("sb_wstrb", {28'd0, o_wstrb}, 32'h8);
        chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
        // LB / LBU 0x102 with rvalid 4 cycles after ready
        run_op(1, 0, 3'b000, 32'h102, 32'd0, 32'h12805634, 0, 4);
        chk("lb_readdata", o_rd, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h102, 32'd0, 32'h12805634, 0, 4);
        chk("lbu_readdata", o_rd, 32'h00000080);
        run_op(1, 0, 3'b001, 32'h102, 32'd0, 32'h8001FFFF, 1, 0);
        chk("lh_hi_readdata", o_rd, 32'hFFFF8001);
        // Illegal accesses
        run_op(1, 0, 3'b001, 32'h101, 32'd0, 32'd0, 0, 0);
        chk("lh_mis_fault", 32'(o_fault_n), 32'd1);
        chk("lh_mis_novalid", 32'(o_valid_n), 32'd0);
        run_op(0, 1, 3'b010, 32'h102, 32'h1234, 32'd0, 0, 0);
        chk("sw_mis_fault", 32'(o_fault_n), 32'd1);
        chk("sw_mis_novalid", 32'(o_valid_n), 32'd0);
        run_op(1, 0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 0);
        chk("f3_011_fault", 32'(o_fault_n), 32'd1);
        chk("f3_011_novalid", 32'(o_valid_n), 32'd0);
        // Timeout: ready never comes
        run_op(1, 0, 3'b010, 32'h300, 32'd0, 32'd0, 30, 0);
        chk("to_valid_cycles", 32'(o_valid_n), 32'd8);
        chk("to_err_pulses", 32'(o_err_n), 32'd1);
        chk("to_readdata", o_rd, 32'd0);
        chk("to_stall_cycles", 32'(o_stall_n), 32'd9);

        // Reset asserted while in REQ
        MemRead = 1; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        MemRead = 0;
        chk1("req_valid_pre_rst", bus_valid, 1'b1);
        reset = 1'b0; #1;
        chk1("rst_in_req_valid", bus_valid, 1'b0);
        chk1("rst_in_req_stall", Stall, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        // Reset asserted while in WAIT
        MemRead = 1; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        MemRead = 0; bus_ready = 1;
        @(posedge clk); #1;
        bus_ready = 0;
        chk1("wait_stall_pre_rst", Stall, 1'b1);
        reset = 1'b0; #1;
        chk1("rst_in_wait_stall", Stall, 1'b0);
        chk1("rst_in_wait_valid", bus_valid, 1'b0);
        chk("rst_in_wait_addr", bus_addr, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_idle_stall", Stall, 1'b0);
        run_op(1, 0, 3'b010, 32'h204, 32'd0, 32'hCAFEF00D, 1, 2);
        chk("post_rst_lw", o_rd, 32'hCAFEF00D);

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            op    = int'($urandom_range(0, 2));
            f3r   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                                : int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0 && op == 0) f3r = int'($urandom_range(4, 5));
            rdly  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 12))
                                                : int'($urandom_range(0, 3));
            rvdly = int'($urandom_range(0, 6));
            run_op(op != 1, op != 0, 3'(f3r), $urandom, $urandom, $urandom, rdly, rvdly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
